// File: rtl/step_dir_input_pkg.sv
// rtl/step_dir_input_pkg.sv - shared constants and FSM encoding for step_dir_input
package step_dir_input_pkg;

    // Width of the per-pin stability counter and of the direction age counter
    localparam int FILT_CNT_W = 4;
    localparam int AGE_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } step_state_t;

endpackage

// File: rtl/step_dir_input_sync_filter.sv
// rtl/step_dir_input_sync_filter.sv - 2-FF synchroniser plus stability-count glitch filter
module step_dir_input_sync_filter
    import step_dir_input_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    localparam logic [FILT_CNT_W-1:0] LEN = FILT_CNT_W'(FILTER_LEN);

    logic                  meta;
    logic                  synced;
    logic [FILT_CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= din;
            synced <= meta;
        end
    end

    // Output follows the synced value only after FILTER_LEN consecutive disagreeing cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (synced == dout) begin
            cnt <= '0;
        end else if (cnt + 1'b1 == LEN) begin
            cnt  <= '0;
            dout <= synced;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/step_dir_input.sv
// rtl/step_dir_input.sv - STEP/DIR/EN pin conditioner with position tracking; STEPDIR_DUAL_EDGE_EN steps on both edges
module step_dir_input
    import step_dir_input_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int DIR_SETUP  = 2,
    parameter int POS_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic                        step_in,
    input  logic                        dir_in,
    input  logic                        en_in,
    input  logic                        clear_pos,
    output logic                        step_out,
    output logic                        dir_out,
    output logic                        enable_out,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        dir_err
);

    localparam logic [AGE_W-1:0]            AGE_MAX   = '1;
    localparam logic [AGE_W-1:0]            SETUP_CYC = AGE_W'(DIR_SETUP);
    localparam logic signed [POS_WIDTH-1:0] POS_PLUS  = POS_WIDTH'(1);
    localparam logic signed [POS_WIDTH-1:0] POS_MINUS = '1;

    logic             step_f;
    logic             dir_f;
    logic             en_f;
    logic             step_prev;
    logic             dir_prev;
    logic             step_edge;
    logic [AGE_W-1:0] dir_age;
    logic             setup_bad;
    logic             strobe;
    logic signed [POS_WIDTH-1:0] pos_base;
    step_state_t      state;
    step_state_t      next_state;

    step_dir_input_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filt (
        .clk    (CLK),
        .resetn (resetn),
        .din    (step_in),
        .dout   (step_f)
    );

    step_dir_input_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filt (
        .clk    (CLK),
        .resetn (resetn),
        .din    (dir_in),
        .dout   (dir_f)
    );

    step_dir_input_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_en_filt (
        .clk    (CLK),
        .resetn (resetn),
        .din    (en_in),
        .dout   (en_f)
    );

    assign enable_out = en_f;
    assign step_out   = strobe;

`ifdef STEPDIR_DUAL_EDGE_EN
    assign step_edge = step_f ^ step_prev;
`else
    assign step_edge = step_f & ~step_prev;
`endif

    assign setup_bad = (dir_age < SETUP_CYC);
    assign pos_base  = clear_pos ? '0 : position;

    // One-cycle history of the filtered step and dir for edge detection
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            step_prev <= 1'b0;
            dir_prev  <= 1'b0;
        end else begin
            step_prev <= step_f;
            dir_prev  <= dir_f;
        end
    end

    // Cycles since the filtered dir last changed, saturating
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            dir_age <= '0;
        end else if (dir_f != dir_prev) begin
            dir_age <= '0;
        end else if (dir_age != AGE_MAX) begin
            dir_age <= dir_age + 1'b1;
        end
    end

    // Step FSM state register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Step FSM next state; in dual-edge mode an edge arriving during STROBE is not seen
    always_comb begin
        next_state = state;
        strobe     = 1'b0;
        case (state)
            IDLE: begin
`ifdef STEPDIR_DUAL_EDGE_EN
                if (step_edge && en_f) begin
                    next_state = STROBE;
                end
`else
                if (step_edge) begin
                    next_state = en_f ? STROBE : HOLD;
                end
`endif
            end
            STROBE: begin
                strobe = 1'b1;
`ifdef STEPDIR_DUAL_EDGE_EN
                next_state = IDLE;
`else
                next_state = HOLD;
`endif
            end
            HOLD: begin
                if (!step_f) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Direction latch, position count and sticky setup flag; a clear in the strobe cycle lands first
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            dir_out  <= 1'b0;
            position <= '0;
            dir_err  <= 1'b0;
        end else if (strobe) begin
            dir_out  <= dir_f;
            position <= pos_base + (dir_f ? POS_PLUS : POS_MINUS);
            dir_err  <= setup_bad | (dir_err & ~clear_pos);
        end else if (clear_pos) begin
            position <= '0;
            dir_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_step_dir_input.sv
// tb/tb_step_dir_input.sv - scoreboard bench for step_dir_input with a pin-level reference model
module tb_step_dir_input;

    localparam int F   = 3;
    localparam int S   = 2;
    localparam int LAT = F + 3;

    logic        CLK = 1'b0;
    logic        resetn = 1'b0;
    logic        step_in = 1'b0;
    logic        dir_in = 1'b0;
    logic        en_in = 1'b0;
    logic        clear_pos = 1'b0;
    logic        step_out, dir_out, enable_out, dir_err;
    logic [31:0] position;
    logic        step_out_w, dir_out_w, enable_out_w, dir_err_w;
    logic [3:0]  position_w;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int          at;
        bit          dir;
        bit          err;
        logic [31:0] pos;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] m_pos = '0;
    bit          m_dir = 1'b0;
    bit          m_en = 1'b0;
    bit          m_err = 1'b0;
    bit          m_last_dir = 1'b0;
    int          m_dir_chg = 0;
    int          clr_at = -1;

    step_dir_input #(.FILTER_LEN(F), .DIR_SETUP(S), .POS_WIDTH(32)) dut (
        .CLK(CLK), .resetn(resetn), .step_in(step_in), .dir_in(dir_in), .en_in(en_in),
        .clear_pos(clear_pos), .step_out(step_out), .dir_out(dir_out),
        .enable_out(enable_out), .position(position), .dir_err(dir_err)
    );

    step_dir_input #(.FILTER_LEN(F), .DIR_SETUP(S), .POS_WIDTH(4)) dut_w (
        .CLK(CLK), .resetn(resetn), .step_in(step_in), .dir_in(dir_in), .en_in(en_in),
        .clear_pos(clear_pos), .step_out(step_out_w), .dir_out(dir_out_w),
        .enable_out(enable_out_w), .position(position_w), .dir_err(dir_err_w)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // A qualifying pin edge driven now yields a strobe LAT cycles later
    task automatic model_edge(input bit rising);
        exp_t e;
        bit   take;
        bit   clr;
`ifdef STEPDIR_DUAL_EDGE_EN
        take = m_en;
`else
        take = rising && m_en;
`endif
        if (take) begin
            clr   = (clr_at == cyc + LAT);
            m_pos = (clr ? 32'd0 : m_pos) + (m_dir ? 32'd1 : 32'hFFFF_FFFF);
            m_err = ((cyc - m_dir_chg) < S) | (m_err & !clr);
            m_last_dir = m_dir;
            e.at  = cyc + LAT;
            e.dir = m_dir;
            e.err = m_err;
            e.pos = m_pos;
            sbq.push_back(e);
        end
    endtask

    task automatic set_dir(input bit d);
        if (d != m_dir) m_dir_chg = cyc;
        m_dir  = d;
        dir_in = d;
    endtask

    task automatic set_en(input bit e);
        m_en  = e;
        en_in = e;
    endtask

    task automatic pulse(input int hi, input int lo);
        step_in = 1'b1;
        if (hi >= F) model_edge(1'b1);
        tick(hi);
        step_in = 1'b0;
        if (hi >= F) model_edge(1'b0);
        tick(lo);
    endtask

    task automatic do_clear();
        tick(LAT + 3);
        clear_pos = 1'b1;
        m_pos = '0;
        m_err = 1'b0;
        tick(1);
        clear_pos = 1'b0;
    endtask

    task automatic quiet_check(input string tag);
        tick(LAT + 3);
        check({tag, "_pos"}, position, m_pos);
        check({tag, "_pos_w"}, {28'd0, position_w}, {28'd0, m_pos[3:0]});
        check({tag, "_dir_err"}, {31'd0, dir_err}, {31'd0, m_err});
        check({tag, "_dir_err_w"}, {31'd0, dir_err_w}, {31'd0, m_err});
        check({tag, "_dir_out"}, {31'd0, dir_out}, {31'd0, m_last_dir});
        check({tag, "_dir_out_w"}, {31'd0, dir_out_w}, {31'd0, m_last_dir});
        check({tag, "_enable"}, {31'd0, enable_out}, {31'd0, m_en});
        check({tag, "_enable_w"}, {31'd0, enable_out_w}, {31'd0, m_en});
    endtask

    // Monitor: every strobe pops one expectation and checks timing and the registered results
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (resetn && step_out) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("strobe_cycle", cyc, e.at);
                    check("strobe_w", {31'd0, step_out_w}, 32'd1);
                    @(negedge CLK);
                    check("strobe_width", {31'd0, step_out}, 32'd0);
                    check("strobe_dir", {31'd0, dir_out}, {31'd0, e.dir});
                    check("strobe_pos", position, e.pos);
                    check("strobe_pos_w", {28'd0, position_w}, {28'd0, e.pos[3:0]});
                    check("strobe_err", {31'd0, dir_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        tick(3);
        check("rst_step_out", {31'd0, step_out}, 32'd0);
        check("rst_dir_out", {31'd0, dir_out}, 32'd0);
        check("rst_enable", {31'd0, enable_out}, 32'd0);
        check("rst_position", position, 32'd0);
        check("rst_dir_err", {31'd0, dir_err}, 32'd0);
        resetn = 1'b1;
        set_dir(1'b1);
        set_en(1'b1);
        tick(20);

        repeat (4) pulse(8, 8);
        quiet_check("fwd4");
        repeat (5) pulse($urandom_range(F, F + 4), $urandom_range(F + 1, F + 5));
        quiet_check("wrap");

        repeat (4) pulse(2, 6);
        quiet_check("glitch");

        set_dir(1'b0);
        tick(1);
        pulse(8, 8);
        quiet_check("setup");
        pulse(8, 8);
        quiet_check("err_sticky");
        do_clear();
        quiet_check("clear");

        set_en(1'b0);
        tick(F + 4);
        repeat (3) pulse(8, 8);
        quiet_check("disabled");
        step_in = 1'b1;
        model_edge(1'b1);
        tick(F + 4);
        set_en(1'b1);
        tick(F + 4);
        step_in = 1'b0;
        model_edge(1'b0);
        tick(8);
        quiet_check("en_while_high");
        pulse(8, 8);
        quiet_check("reenable");

        step_in = 1'b1;
        clr_at = cyc + LAT;
        model_edge(1'b1);
        tick(LAT);
        clear_pos = 1'b1;
        tick(1);
        clear_pos = 1'b0;
        tick(4);
        step_in = 1'b0;
        model_edge(1'b0);
        clr_at = -1;
        tick(8);
        quiet_check("clr_coinc");

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0, 1, 2, 3: pulse($urandom_range(F, F + 5), $urandom_range(F + 1, F + 6));
                4: pulse($urandom_range(1, F - 1), $urandom_range(F + 1, F + 3));
                5: begin
                    set_dir(!m_dir);
                    tick($urandom_range(1, 4));
                    pulse($urandom_range(F, F + 5), $urandom_range(F + 1, F + 6));
                end
                6: begin
                    set_en(!m_en);
                    tick(F + 4);
                end
                default: do_clear();
            endcase
        end

        for (int i = 0; i < 200 && sbq.size() != 0; i++) tick(1);
        check("queue_drained", sbq.size(), 32'd0);
        quiet_check("final");

        set_en(1'b1);
        tick(F + 4);
        step_in = 1'b1;
        tick(LAT);
        check("pre_reset_strobe", {31'd0, step_out}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("abort_step_out", {31'd0, step_out}, 32'd0);
        check("abort_step_out_w", {31'd0, step_out_w}, 32'd0);
        check("abort_position", position, 32'd0);
        check("abort_dir_err", {31'd0, dir_err}, 32'd0);
        check("abort_enable", {31'd0, enable_out}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
